// File: rtl/riscv_pkg.sv
// Shared RV32 constants for the front end: NOP encoding, major opcodes, XLEN.
package riscv_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OP_I_IMM  = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_S      = 7'b0100011;
  localparam logic [6:0]  OP_B      = 7'b1100011;
  localparam logic [6:0]  OP_R      = 7'b0110011;
endpackage

// File: rtl/fetch_pair_fifo.sv
// Synchronous FIFO of {pc, instr1, instr2} entries; head is read straight from the storage registers.
module fetch_pair_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 96,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Flush beats a same-cycle push.
  assign w_push  = i_push & ~i_flush;
  assign w_pop   = i_pop & ~o_empty;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/fetch_pair_unit.sv
// Dual-issue fetch front end: owns the PC, drives the pair-ROM address and buffers tagged pairs for decode.
module fetch_pair_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter int          AW       = 10
) (
  input  logic            clk,
  input  logic            rst,
  output logic [AW-1:0]   rom_addr,
  input  logic [XLEN-1:0] rom_instr1,
  input  logic [XLEN-1:0] rom_instr2,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr1,
  output logic [XLEN-1:0] if_instr2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] r_fetch_pc, r_req_pc, r_if_pc;
  logic            r_req_pending;

  logic [XLEN-1:0] w_redir_pc, w_base_pc;
  logic [XLEN-1:0] w_head_pc, w_head_i1, w_head_i2;
  logic [3*XLEN-1:0] w_head;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occ;
  logic            w_pop, w_push, w_redir, w_issue, w_full, w_empty;

  assign w_redir_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_redir    = redirect_valid & ~rst;
  assign w_pop      = if_valid & if_ready;
  // Slots already claimed: buffered pairs plus the read in flight, less the one leaving now.
  assign w_occ      = {1'b0, w_count} + (CW+1)'(r_req_pending) - (CW+1)'(w_pop);
  assign w_issue    = ~rst & (redirect_valid | (w_occ < (CW+1)'(DEPTH)));
  assign w_base_pc  = w_redir ? w_redir_pc : r_fetch_pc;
  assign rom_addr   = rst ? RESET_PC[AW+1:2] : w_base_pc[AW+1:2];
  // Data returning during a redirect belongs to the abandoned path.
  assign w_push     = r_req_pending & ~redirect_valid;

  fetch_pair_fifo #(.DEPTH(DEPTH), .W(3*XLEN)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .i_data  ({r_req_pc, rom_instr1, rom_instr2}),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign {w_head_pc, w_head_i1, w_head_i2} = w_head;
  assign if_valid  = ~w_empty;
  assign if_pc     = if_valid ? w_head_pc : r_if_pc;
  assign if_instr1 = if_valid ? w_head_i1 : NOP_INSTR;
  assign if_instr2 = if_valid ? w_head_i2 : NOP_INSTR;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_req_pc      <= RESET_PC;
      r_req_pending <= 1'b0;
      r_if_pc       <= RESET_PC;
    end else begin
      r_req_pending <= w_issue;
      if (w_issue) begin
        r_req_pc   <= w_base_pc;
        r_fetch_pc <= w_base_pc + 32'd8;
      end
      if (if_valid) r_if_pc <= w_head_pc;
    end
  end

  // Issue throttling guarantees a returning pair always has a free slot.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(w_push && !w_redir && w_full));
  end
endmodule

// File: tb/tb_fetch_pair_unit.sv
// Bench for fetch_pair_unit: directed scenarios plus a randomized run against an expected-PC stream model.
module tb_fetch_pair_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic [9:0]  rom_addr;
  logic [31:0] rom_instr1 = '0, rom_instr2 = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid, if_ready = 1'b0;
  logic [31:0] if_pc, if_instr1, if_instr2;
  int          n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  // ROM model: rom[i] = i, pair read registered, second word wraps modulo 1024.
  always @(posedge clk) begin
    rom_instr1 <= {22'b0, rom_addr};
    rom_instr2 <= {22'b0, rom_addr + 10'd1};
  end

  fetch_pair_unit #(.RESET_PC(32'h0), .DEPTH(2), .AW(10)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_instr1(rom_instr1), .rom_instr2(rom_instr2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_ready(if_ready), .if_pc(if_pc), .if_instr1(if_instr1), .if_instr2(if_instr2)
  );

  function automatic logic [31:0] wd(input logic [31:0] pc);
    return {22'b0, pc[11:2]};
  endfunction

  task automatic cyc(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rp; if_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1);
      n_checks++;
      if (if_valid !== 1'b0 || if_instr1 !== NOP_INSTR || if_instr2 !== NOP_INSTR || if_pc !== 32'h0 || rom_addr !== 10'd0)
        $display("FAIL reset[%0d] valid=%b i1=%h i2=%h pc=%h addr=%0d exp 0/00000013/00000013/0/0", i, if_valid, if_instr1, if_instr2, if_pc, rom_addr);
      else n_pass++;
    end
    cyc(0, 0, 0, 1);
    n_checks++;
    if (if_valid !== 1'b0 || rom_addr !== 10'd0)
      $display("FAIL release_c0 valid=%b addr=%0d exp 0/0", if_valid, rom_addr);
    else n_pass++;
    cyc(0, 0, 0, 1);
    n_checks++;
    if (if_valid !== 1'b0 || rom_addr !== 10'd2)
      $display("FAIL release_c1 valid=%b addr=%0d exp 0/2", if_valid, rom_addr);
    else n_pass++;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ep;
      ep = 32'(8 * i);
      cyc(0, 0, 0, 1);
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== ep || if_instr1 !== wd(ep) || if_instr2 !== wd(ep + 4))
        $display("FAIL stream[%0d] valid=%b pc=%h i1=%h i2=%h exp pc=%h i1=%h i2=%h", i, if_valid, if_pc, if_instr1, if_instr2, ep, wd(ep), wd(ep + 4));
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [9:0] ra;
    ra = '0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0);
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'd48 || if_instr1 !== 32'd12 || if_instr2 !== 32'd13)
        $display("FAIL stall_hold[%0d] valid=%b pc=%h i1=%h i2=%h exp 1/30/c/d", i, if_valid, if_pc, if_instr1, if_instr2);
      else n_pass++;
      if (i == 1) ra = rom_addr;
      if (i >= 1) begin
        n_checks++;
        if (dut.u_fifo.o_count !== 2'd2 || (i > 1 && rom_addr !== ra))
          $display("FAIL stall_full[%0d] count=%0d addr=%0d exp count=2 addr=%0d", i, dut.u_fifo.o_count, rom_addr, ra);
        else n_pass++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ep;
      ep = 32'(48 + 8 * i);
      cyc(0, 0, 0, 1);
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== ep || if_instr1 !== wd(ep) || if_instr2 !== wd(ep + 4))
        $display("FAIL resume[%0d] valid=%b pc=%h i1=%h exp pc=%h i1=%h", i, if_valid, if_pc, if_instr1, ep, wd(ep));
      else n_pass++;
    end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h40, 0);
    n_checks++;
    if (rom_addr !== 10'd16) $display("FAIL redir_addr addr=%0d exp 16", rom_addr);
    else n_pass++;
    cyc(0, 0, 0, 1);
    n_checks++;
    if (if_valid !== 1'b0 || if_instr1 !== NOP_INSTR) $display("FAIL redir_flush valid=%b i1=%h exp 0/00000013", if_valid, if_instr1);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      logic [31:0] ep;
      ep = 32'h40 + 32'(8 * i);
      cyc(0, 0, 0, 1);
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== ep || if_instr1 !== wd(ep) || if_instr2 !== wd(ep + 4))
        $display("FAIL redir_pair[%0d] valid=%b pc=%h i1=%h i2=%h exp pc=%h i1=%h i2=%h", i, if_valid, if_pc, if_instr1, if_instr2, ep, wd(ep), wd(ep + 4));
      else n_pass++;
    end
  endtask

  task automatic test_wrap_odd();
    cyc(0, 1, 32'hFFC, 1);
    n_checks++;
    if (rom_addr !== 10'd1023) $display("FAIL wrap_addr addr=%0d exp 1023", rom_addr);
    else n_pass++;
    cyc(0, 0, 0, 1);
    n_checks++;
    if (rom_addr !== 10'd1 || if_valid !== 1'b0) $display("FAIL wrap_next addr=%0d valid=%b exp 1/0", rom_addr, if_valid);
    else n_pass++;
    cyc(0, 0, 0, 1);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'hFFC || if_instr1 !== 32'd1023 || if_instr2 !== 32'd0)
      $display("FAIL wrap_pair valid=%b pc=%h i1=%h i2=%h exp 1/ffc/3ff/0", if_valid, if_pc, if_instr1, if_instr2);
    else n_pass++;
    cyc(0, 0, 0, 1);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h1004 || if_instr1 !== 32'd1 || if_instr2 !== 32'd2)
      $display("FAIL wrap_pair2 valid=%b pc=%h i1=%h i2=%h exp 1/1004/1/2", if_valid, if_pc, if_instr1, if_instr2);
    else n_pass++;
    cyc(0, 1, 32'h106, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h104 || if_instr1 !== 32'h41 || if_instr2 !== 32'h42)
      $display("FAIL odd_pair valid=%b pc=%h i1=%h i2=%h exp 1/104/41/42", if_valid, if_pc, if_instr1, if_instr2);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
      cyc(1, v[0], 32'h200, 0);
      n_checks++;
      if (rom_addr !== 10'd0) $display("FAIL midrst_addr[%0d] addr=%0d exp 0", v, rom_addr);
      else n_pass++;
      cyc(0, 0, 0, 1);
      n_checks++;
      if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr1 !== NOP_INSTR || rom_addr !== 10'd0)
        $display("FAIL midrst_clear[%0d] valid=%b pc=%h i1=%h addr=%0d exp 0/0/00000013/0", v, if_valid, if_pc, if_instr1, rom_addr);
      else n_pass++;
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 2; i++) begin
        logic [31:0] ep;
        ep = 32'(8 * i);
        cyc(0, 0, 0, 1);
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== ep || if_instr1 !== wd(ep) || if_instr2 !== wd(ep + 4))
          $display("FAIL midrst_pair[%0d.%0d] valid=%b pc=%h i1=%h exp pc=%h i1=%h", v, i, if_valid, if_pc, if_instr1, ep, wd(ep));
        else n_pass++;
      end
    end
  endtask

  // Model: the accepted stream is consecutive pairs from the last restart point;
  // the head must be valid from the second cycle after a redirect and the third after reset.
  task automatic test_random();
    logic [31:0] exp_pc, rp;
    logic        r, rv, rdy;
    int          since;
    cyc(1, 0, 0, 1);
    exp_pc = 32'h0;
    since  = 0;
    for (int n = 0; n < 800; n++) begin
      r   = ($urandom_range(0, 59) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      rp  = ($urandom_range(0, 3) == 0) ? 32'hFF0 + 32'($urandom_range(0, 15)) : ($urandom & 32'h0000_3FFF);
      rdy = ($urandom_range(0, 3) != 0);
      cyc(r, rv, rp, rdy);
      n_checks++;
      if (if_valid === 1'b1) begin
        if (if_pc !== exp_pc || if_instr1 !== wd(exp_pc) || if_instr2 !== wd(exp_pc + 4))
          $display("FAIL rand_pair[%0d] pc=%h i1=%h i2=%h exp pc=%h i1=%h i2=%h", n, if_pc, if_instr1, if_instr2, exp_pc, wd(exp_pc), wd(exp_pc + 4));
        else n_pass++;
      end else if (since >= 2 || if_instr1 !== NOP_INSTR || if_instr2 !== NOP_INSTR) begin
        $display("FAIL rand_empty[%0d] valid=%b i1=%h i2=%h since=%0d exp valid or NOP", n, if_valid, if_instr1, if_instr2, since);
      end else n_pass++;
      if (r || rv) begin
        n_checks++;
        if (rom_addr !== (r ? 10'd0 : rp[11:2])) $display("FAIL rand_addr[%0d] addr=%0d exp %0d", n, rom_addr, r ? 10'd0 : rp[11:2]);
        else n_pass++;
      end
      if (r) begin
        exp_pc = 32'h0; since = 0;
      end else if (rv) begin
        exp_pc = rp & ~32'd3; since = 1;
      end else begin
        if (if_valid === 1'b1 && rdy) exp_pc = exp_pc + 32'd8;
        if (since < 10) since++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap_odd();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
